// File: rtl/rh_qlpi_pwr_ctrl.sv
// Q-channel power controller: stops NDEV devices in ascending order, wakes them
// in descending order, and rolls back already-stopped devices on a denial.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_STOPPED  | every device accepted quiescence; QREQn all low
// ST_EXIT     | releasing device idx, waiting for its QACCEPTn to rise
// ST_RUN      | all devices running; waiting for a power-down request
// ST_REQUEST  | QREQn of device idx low, waiting for accept or deny
// ST_DENIED   | device idx denied; held for one cycle before releasing
// ST_CONTINUE | QREQn of device idx released, waiting for QDENY to drop
module rh_qlpi_pwr_ctrl #(
  parameter int NDEV    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      pwr_down_req,
  output logic [NDEV-1:0]                           qreqn_o,
  input  logic [NDEV-1:0]                           qacceptn_i,
  input  logic [NDEV-1:0]                           qdeny_i,
  input  logic [NDEV-1:0]                           qactive_i,
  output logic [2:0]                                pwr_state_o,
  output logic [((NDEV > 1) ? $clog2(NDEV) : 1)-1:0] cur_dev_o,
  output logic                                      done_o,
  output logic                                      deny_o,
  output logic                                      timeout_o,
  output logic                                      err_o
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDEV - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  // Encodings match the lpi state ordinals so pwr_state_o is the state register.
  typedef enum logic [2:0] {
    ST_STOPPED  = 3'd0,
    ST_EXIT     = 3'd1,
    ST_RUN      = 3'd2,
    ST_REQUEST  = 3'd3,
    ST_DENIED   = 3'd4,
    ST_CONTINUE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [NDEV-1:0]   qreqn_q, qreqn_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              deny_q, deny_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;

  logic              acc_n;
  logic              dny;
  logic [IW-1:0]     idx_nxt;
  logic [IW-1:0]     idx_prv;

  assign acc_n   = qacceptn_i[idx_q];
  assign dny     = qdeny_i[idx_q];
  assign idx_nxt = idx_q + IW'(1);
  assign idx_prv = idx_q - IW'(1);

  always_comb begin
    state_d   = state_q;
    qreqn_d   = qreqn_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    deny_d    = 1'b0;
    timeout_d = timeout_q;
    err_d     = err_q;

    case (state_q)
      ST_RUN: begin
        if (pwr_down_req && (qactive_i == '0)) begin
          idx_d      = '0;
          qreqn_d[0] = 1'b0;
          cnt_d      = '0;
          timeout_d  = 1'b0;
          state_d    = ST_REQUEST;
        end
      end

      ST_REQUEST: begin
        // Timeout is only a flag; the handshake keeps waiting regardless.
        if ((TIMEOUT != 0) && (cnt_q != TMAX)) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMAX) timeout_d = 1'b1;
        end
        if (dny) begin
          deny_d  = 1'b1;
          state_d = ST_DENIED;
          if (!acc_n) err_d = 1'b1;
        end else if (!acc_n) begin
          if (idx_q == LAST) begin
            done_d  = 1'b1;
            state_d = ST_STOPPED;
          end else begin
            idx_d            = idx_nxt;
            qreqn_d[idx_nxt] = 1'b0;
            cnt_d            = '0;
          end
        end
      end

      ST_DENIED: begin
        qreqn_d[idx_q] = 1'b1;
        state_d        = ST_CONTINUE;
      end

      ST_CONTINUE: begin
        if (acc_n) err_d = 1'b1;
        if (!dny) begin
          if (idx_q == '0) begin
            state_d = ST_RUN;
          end else begin
            idx_d            = idx_prv;
            qreqn_d[idx_prv] = 1'b1;
            state_d          = ST_EXIT;
          end
        end
      end

      ST_STOPPED: begin
        if (!pwr_down_req || (qactive_i != '0)) begin
          idx_d         = LAST;
          qreqn_d[LAST] = 1'b1;
          state_d       = ST_EXIT;
        end
      end

      ST_EXIT: begin
        if (dny) err_d = 1'b1;
        if (acc_n) begin
          if (idx_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            idx_d            = idx_prv;
            qreqn_d[idx_prv] = 1'b1;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      qreqn_q   <= '1;
      idx_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      deny_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qreqn_q   <= qreqn_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      deny_q    <= deny_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign qreqn_o     = qreqn_q;
  assign pwr_state_o = state_q;
  assign cur_dev_o   = idx_q;
  assign done_o      = done_q;
  assign deny_o      = deny_q;
  assign timeout_o   = timeout_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rh_qlpi_pwr_ctrl.sv
// Bench for rh_qlpi_pwr_ctrl (NDEV=4, TIMEOUT=10): per-cycle vectors whose
// expected outputs are queued when driven and compared after the clock edge.
module tb_rh_qlpi_pwr_ctrl;

  localparam logic [3:0] F = 4'hF;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pwr_down_req = 1'b0;
  logic [3:0] qreqn_o, qacceptn_i, qdeny_i, qactive_i;
  logic [2:0] pwr_state_o;
  logic [1:0] cur_dev_o;
  logic       done_o, deny_o, timeout_o, err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic       req;
    logic [3:0] acc, dny, act;
    logic       rstn;
    logic [3:0] q;
    logic [2:0] st;
    logic [1:0] cur;
    logic       done, deny, to, err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  rh_qlpi_pwr_ctrl #(.NDEV(4), .TIMEOUT(10)) dut (
    .clk(clk), .resetn(resetn), .pwr_down_req(pwr_down_req),
    .qreqn_o(qreqn_o), .qacceptn_i(qacceptn_i), .qdeny_i(qdeny_i),
    .qactive_i(qactive_i), .pwr_state_o(pwr_state_o), .cur_dev_o(cur_dev_o),
    .done_o(done_o), .deny_o(deny_o), .timeout_o(timeout_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic req,
                              input logic [3:0] acc, dny, act, input logic rstn,
                              input logic [3:0] q, input logic [2:0] st,
                              input logic [1:0] cur,
                              input logic done, deny, to, err);
    vec_t v;
    v.name = name; v.req = req; v.acc = acc; v.dny = dny; v.act = act;
    v.rstn = rstn; v.q = q; v.st = st; v.cur = cur;
    v.done = done; v.deny = deny; v.to = to; v.err = err;
    return v;
  endfunction

  // Stop handshakes for devices first..last; each device answers one cycle
  // after it sees its QREQn low, so each device costs two edges.
  task automatic add_stop(input int first, input int last, input logic err);
    logic [3:0] a, q;
    for (int d = first; d <= last; d++) begin
      a = F << d;
      q = F << (d + 1);
      tbl.push_back(mk("stop", 1'b1, a, 4'h0, 4'h0, 1'b1, q, 3'd3, d[1:0], 1'b0, 1'b0, 1'b0, err));
      tbl.push_back(mk("stop_wait", 1'b1, a, 4'h0, 4'h0, 1'b1, q, 3'd3, d[1:0], 1'b0, 1'b0, 1'b0, err));
    end
  endtask

  task automatic add_exit(input logic req, input logic [3:0] act);
    logic [3:0] a, q;
    for (int d = 3; d >= 0; d--) begin
      a = F << (d + 1);
      q = F << d;
      tbl.push_back(mk("exit", req, a, 4'h0, act, 1'b1, q, 3'd1, d[1:0], 1'b0, 1'b0, 1'b0, 1'b0));
      tbl.push_back(mk("exit_wait", req, a, 4'h0, act, 1'b1, q, 3'd1, d[1:0], 1'b0, 1'b0, 1'b0, 1'b0));
    end
    tbl.push_back(mk("exit_done", req, F, 4'h0, act, 1'b1, F, 3'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    pwr_down_req = v.req;
    qacceptn_i   = v.acc;
    qdeny_i      = v.dny;
    qactive_i    = v.act;
    resetn       = v.rstn;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({qreqn_o, pwr_state_o, cur_dev_o, done_o, deny_o, timeout_o, err_o} !==
        {e.q, e.st, e.cur, e.done, e.deny, e.to, e.err}) begin
      failures++;
      $display("FAIL %s (check %0d): got qreqn=%b st=%0d cur=%0d done=%b deny=%b to=%b err=%b, want qreqn=%b st=%0d cur=%0d done=%b deny=%b to=%b err=%b",
               e.name, checks, qreqn_o, pwr_state_o, cur_dev_o, done_o, deny_o, timeout_o, err_o,
               e.q, e.st, e.cur, e.done, e.deny, e.to, e.err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    qacceptn_i = F; qdeny_i = 4'h0; qactive_i = 4'h0;

    // reset, idle and qactive blocking
    tbl.push_back(mk("reset", 0, F, 0, 0, 0, F, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("idle", 0, F, 0, 0, 1, F, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("qactive_blk", 1, F, 0, 4'b0001, 1, F, 2, 0, 0, 0, 0, 0));
    // full stop then release by dropping the request
    add_stop(0, 3, 1'b0);
    tbl.push_back(mk("stop_done", 1, 4'h0, 0, 0, 1, 4'h0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk("stopped_hold", 1, 4'h0, 0, 0, 1, 4'h0, 0, 3, 0, 0, 0, 0));
    add_exit(1'b0, 4'h0);
    // device 2 denies; released devices still report QACCEPTn high in QContinue
    add_stop(0, 2, 1'b0);
    tbl.push_back(mk("deny", 1, 4'b1100, 4'b0100, 0, 1, 4'b1000, 4, 2, 0, 1, 0, 0));
    tbl.push_back(mk("denied", 1, 4'b1100, 4'b0100, 0, 1, 4'b1100, 5, 2, 0, 0, 0, 0));
    tbl.push_back(mk("continue", 1, 4'b1100, 4'b0100, 0, 1, 4'b1100, 5, 2, 0, 0, 0, 1));
    tbl.push_back(mk("rollback1", 1, 4'b1100, 4'b0000, 0, 1, 4'b1110, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk("rollback1_w", 1, 4'b1100, 4'b0000, 0, 1, 4'b1110, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk("rollback0", 1, 4'b1110, 4'b0000, 0, 1, F, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rollback0_w", 1, 4'b1110, 4'b0000, 0, 1, F, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("rollback_done", 1, F, 4'b0000, 0, 1, F, 2, 0, 1, 0, 0, 1));
    tbl.push_back(mk("reset2", 0, F, 0, 0, 0, F, 2, 0, 0, 0, 0, 0));
    // accept and deny together on device 0
    tbl.push_back(mk("ad_req", 1, F, 0, 0, 1, 4'b1110, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk("ad_both", 1, 4'b1110, 4'b0001, 0, 1, 4'b1110, 4, 0, 0, 1, 0, 1));
    tbl.push_back(mk("ad_denied", 1, 4'b1110, 4'b0001, 0, 1, F, 5, 0, 0, 0, 0, 1));
    tbl.push_back(mk("ad_run", 0, F, 0, 0, 1, F, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("reset3", 0, F, 0, 0, 0, F, 2, 0, 0, 0, 0, 0));
    // stop, then wake on qactive[3] with the request still high
    add_stop(0, 3, 1'b0);
    tbl.push_back(mk("stop_done2", 1, 4'h0, 0, 0, 1, 4'h0, 0, 3, 1, 0, 0, 0));
    add_exit(1'b1, 4'b1000);
    tbl.push_back(mk("wake_idle", 1, F, 0, 4'b1000, 1, F, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wake_drop", 0, F, 0, 0, 1, F, 2, 0, 0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // device 1 silent for 20 cycles with TIMEOUT=10
    step(mk("to_start", 1, F, 0, 0, 1, 4'b1110, 3, 0, 0, 0, 0, 0));
    step(mk("to_dev0", 1, 4'b1110, 0, 0, 1, 4'b1100, 3, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++)
      step(mk("to_wait", 1, 4'b1110, 0, 0, 1, 4'b1100, 3, 1, 0, 0, (k >= 10), 0));
    step(mk("to_dev1", 1, 4'b1100, 0, 0, 1, 4'b1000, 3, 2, 0, 0, 1, 0));
    step(mk("to_dev2", 1, 4'b1000, 0, 0, 1, 4'b0000, 3, 3, 0, 0, 1, 0));
    step(mk("to_stopped", 1, 4'b0000, 0, 0, 1, 4'b0000, 0, 3, 1, 0, 1, 0));
    step(mk("to_exit3", 0, 4'b0000, 0, 0, 1, 4'b1000, 1, 3, 0, 0, 1, 0));
    step(mk("to_exit2", 0, 4'b1000, 0, 0, 1, 4'b1100, 1, 2, 0, 0, 1, 0));
    step(mk("to_exit1", 0, 4'b1100, 0, 0, 1, 4'b1110, 1, 1, 0, 0, 1, 0));
    step(mk("to_exit0", 0, 4'b1110, 0, 0, 1, F, 1, 0, 0, 0, 1, 0));
    step(mk("to_run", 0, F, 0, 0, 1, F, 2, 0, 1, 0, 1, 0));
    step(mk("to_clear", 1, F, 0, 0, 1, 4'b1110, 3, 0, 0, 0, 0, 0));

    // reset while device 2 is mid-handshake
    step(mk("mr_dev1", 1, 4'b1110, 0, 0, 1, 4'b1100, 3, 1, 0, 0, 0, 0));
    step(mk("mr_dev2", 1, 4'b1100, 0, 0, 1, 4'b1000, 3, 2, 0, 0, 0, 0));
    step(mk("mr_reset", 1, 4'b1100, 0, 0, 0, F, 2, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
